// File: rtl/delay_driver_pkg.sv
// Shared types and default widths for the delay_driver initiator.
package delay_driver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DATA_SIZE      = 8;
  localparam int CNT_SIZE       = 8;
  localparam int DEPTH          = 4;
  localparam int TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO; a push while full is accepted only if a pop frees the slot at the same edge.
module sync_fifo
  import delay_driver_pkg::*;
#(
  parameter int data_size = DATA_SIZE,
  parameter int depth     = DEPTH,
  parameter int ptr_size  = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [data_size-1:0] push_data,
  input  logic                 pop,
  output logic [data_size-1:0] head,
  output logic                 full,
  output logic                 empty,
  output logic                 multi,
  output logic                 drop
);

  localparam logic [ptr_size:0] LP_FULL = (ptr_size+1)'(depth);

  logic [data_size-1:0] r_mem [depth];
  logic [ptr_size-1:0]  r_wr_ptr, r_rd_ptr;
  logic [ptr_size:0]    r_count;
  logic                 w_pop, w_push;

  assign full   = (r_count == LP_FULL);
  assign empty  = (r_count == '0);
  assign multi  = (r_count[ptr_size:1] != '0);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign drop   = push && !w_push;
  assign head   = r_mem[r_rd_ptr];

  // When full, wr_ptr == rd_ptr: the new word lands in the slot being popped, which becomes the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < depth; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/delay_driver.sv
// Initiator for the valid/next/ready stage handshake: queues words, sends one at a time,
// captures the stage result, and keeps transfer counters and sticky error flags.
module delay_driver
  import delay_driver_pkg::*;
#(
  parameter int data_size      = DATA_SIZE,
  parameter int depth          = DEPTH,
  parameter int ptr_size       = $clog2(depth),
  parameter int cnt_size       = CNT_SIZE,
  parameter int timeout_cycles = TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [data_size-1:0] push_data,
  output logic                 full,
  output logic                 empty,
  output logic                 valid,
  output logic [data_size-1:0] tx_data,
  input  logic                 next,
  input  logic                 ready,
  input  logic [data_size-1:0] rx_data,
  output logic [data_size-1:0] result,
  output logic                 result_valid,
  output logic [cnt_size-1:0]  sent_cnt,
  output logic [cnt_size-1:0]  recv_cnt,
  output logic                 overflow,
  output logic                 timeout_err
);

  localparam logic [cnt_size-1:0] LP_TO_LAST = cnt_size'(timeout_cycles - 1);

  state_t               r_state;
  logic [cnt_size-1:0]  r_timer, r_sent_cnt, r_recv_cnt;
  logic [data_size-1:0] r_result;
  logic                 r_result_valid, r_overflow, r_timeout_err;
  logic [data_size-1:0] w_head;
  logic                 w_xfer, w_capture, w_multi, w_drop;

  sync_fifo #(
    .data_size (data_size),
    .depth     (depth),
    .ptr_size  (ptr_size)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (w_xfer),
    .head      (w_head),
    .full      (full),
    .empty     (empty),
    .multi     (w_multi),
    .drop      (w_drop)
  );

  assign valid     = (r_state == SEND);
  assign tx_data   = valid ? w_head : '0;
  assign w_xfer    = valid && next;
  // ready only counts alongside a transfer or while a result is outstanding.
  assign w_capture = ready && (w_xfer || r_state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      r_sent_cnt     <= '0;
      r_recv_cnt     <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_capture) begin
        r_result       <= rx_data;
        r_result_valid <= 1'b1;
        r_recv_cnt     <= r_recv_cnt + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;

      case (r_state)
        IDLE: if (!empty) r_state <= SEND;
        SEND: begin
          if (next) begin
            r_sent_cnt <= r_sent_cnt + 1'b1;
            r_timer    <= '0;
            if (!ready)       r_state <= WAIT;
            else if (w_multi) r_state <= SEND;
            else              r_state <= IDLE;
          end
        end
        WAIT: begin
          if (ready) begin
            r_state <= empty ? IDLE : SEND;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (r_timer == LP_TO_LAST) begin
              r_timeout_err <= 1'b1;
              r_state       <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign sent_cnt     = r_sent_cnt;
  assign recv_cnt     = r_recv_cnt;
  assign overflow     = r_overflow;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_delay_driver.sv
// Bench for delay_driver: a behavioural stage (zero-latency or delayed reply, result = word ^ 0xFF)
// plus transaction logs compared against the pushed word order and the expected reply latency.
module tb_delay_driver;

  logic       clk = 1'b0;
  logic       reset, push, next, ready;
  logic [7:0] push_data, tx_data, rx_data, result;
  logic       full, empty, valid, result_valid, overflow, timeout_err;
  logic [7:0] sent_cnt, recv_cnt;

  int n_tests = 0, n_fail = 0;
  int exp_sent = 0, exp_recv = 0;

  // stage behaviour knobs: st_mode 0 = never replies, 1 = replies after a delay, 2 = zero-latency
  int   st_mode = 0, st_next = 0, st_dmin = 1, st_dmax = 1;
  bit   st_force = 1'b0;
  logic next_r = 1'b0, ready_r = 1'b0;
  logic [7:0] rx_r = 8'h00, pend_d = 8'h00;
  int   pend = 0, cyc = 0;

  logic [7:0] sent_log[$], res_log[$];
  int         xcyc_log[$], del_log[$], rv_log[$];

  delay_driver dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_data    (push_data),
    .full         (full),
    .empty        (empty),
    .valid        (valid),
    .tx_data      (tx_data),
    .next         (next),
    .ready        (ready),
    .rx_data      (rx_data),
    .result       (result),
    .result_valid (result_valid),
    .sent_cnt     (sent_cnt),
    .recv_cnt     (recv_cnt),
    .overflow     (overflow),
    .timeout_err  (timeout_err)
  );

  assign next    = next_r;
  assign ready   = (st_mode == 2) ? (valid && next) : ready_r;
  assign rx_data = (st_mode == 2) ? (tx_data ^ 8'hFF) : rx_r;

  always #5 clk = ~clk;

  // Stage model and transaction monitor in one process.
  always @(clk) begin
    if (clk === 1'b1) begin
      cyc++;
      if (reset === 1'b0 && valid && next) begin
        sent_log.push_back(tx_data);
        xcyc_log.push_back(cyc);
        if (st_mode == 1) begin
          pend   = $urandom_range(st_dmax, st_dmin);
          pend_d = tx_data;
          del_log.push_back(pend);
        end else begin
          del_log.push_back(0);
        end
      end
    end else begin
      if (result_valid === 1'b1) begin
        res_log.push_back(result);
        rv_log.push_back(cyc);
      end
      ready_r = 1'b0;
      if (reset === 1'b1) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ready_r = 1'b1;
          rx_r    = pend_d ^ 8'hFF;
        end
      end
      if (st_force) begin
        ready_r = 1'b1;
        rx_r    = 8'hEE;
      end
      case (st_next)
        1:       next_r = 1'b1;
        2:       next_r = 1'($urandom_range(1, 0));
        default: next_r = 1'b0;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_push(input logic [7:0] d);
    @(negedge clk);
    push      = 1'b1;
    push_data = d;
    @(posedge clk);
    #1 push = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    exp_sent = 0;
    exp_recv = 0;
  endtask

  task automatic wait_res(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (res_log.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    push = 1'b0; push_data = 8'h00; reset = 1'b1;
    #1;
    n_tests++;
    if ({empty, full, valid, tx_data, result, result_valid, sent_cnt, recv_cnt, overflow, timeout_err}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got e%b f%b v%b tx%h r%h rv%b s%h c%h o%b t%b", empty, full, valid,
               tx_data, result, result_valid, sent_cnt, recv_cnt, overflow, timeout_err);
    end
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_delay1();
    logic [7:0] w [3];
    int s0, r0;
    bit ok;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    st_mode = 1; st_dmin = 1; st_dmax = 1; st_next = 1;
    s0 = sent_log.size(); r0 = res_log.size();
    for (int i = 0; i < 3; i++) do_push(w[i]);
    wait_res(r0 + 3, 100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL delay1_done: got %0d results, want 3", res_log.size() - r0); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (sent_log[s0+i] !== w[i]) begin n_fail++; $display("FAIL delay1_order[%0d]: got %h want %h", i, sent_log[s0+i], w[i]); end
        n_tests++;
        if (res_log[r0+i] !== (w[i] ^ 8'hFF)) begin n_fail++; $display("FAIL delay1_result[%0d]: got %h want %h", i, res_log[r0+i], w[i] ^ 8'hFF); end
        n_tests++;
        if (rv_log[r0+i] - xcyc_log[s0+i] != 1) begin n_fail++; $display("FAIL delay1_latency[%0d]: got %0d want 1", i, rv_log[r0+i] - xcyc_log[s0+i]); end
      end
    end
    repeat (3) @(negedge clk);
    #1;
    exp_sent += 3; exp_recv += 3;
    n_tests++;
    if ({sent_cnt, recv_cnt, empty} !== {8'(exp_sent), 8'(exp_recv), 1'b1}) begin
      n_fail++; $display("FAIL delay1_counts: got s%0d r%0d e%b want s%0d r%0d e1", sent_cnt, recv_cnt, empty, exp_sent, exp_recv);
    end
  endtask

  task automatic test_zero_latency();
    int s0, r0;
    bit ok;
    st_mode = 2; st_next = 1;
    s0 = sent_log.size(); r0 = res_log.size();
    do_push(8'hA5);
    wait_res(r0 + 1, 50, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL zero_done: no result"); end
    else begin
      n_tests++;
      if (res_log[r0] !== 8'h5A) begin n_fail++; $display("FAIL zero_result: got %h want 5a", res_log[r0]); end
      n_tests++;
      if (rv_log[r0] != xcyc_log[s0]) begin n_fail++; $display("FAIL zero_latency: got %0d want 0", rv_log[r0] - xcyc_log[s0]); end
    end
    repeat (2) @(negedge clk);
    #1;
    exp_sent++; exp_recv++;
    n_tests++;
    if ({valid, sent_cnt, recv_cnt} !== {1'b0, 8'(exp_sent), 8'(exp_recv)}) begin
      n_fail++; $display("FAIL zero_counts: got v%b s%0d r%0d want v0 s%0d r%0d", valid, sent_cnt, recv_cnt, exp_sent, exp_recv);
    end
  endtask

  task automatic test_hold();
    int s0, r0, c;
    bit ok;
    st_mode = 1; st_dmin = 1; st_dmax = 1; st_next = 0;
    s0 = sent_log.size(); r0 = res_log.size();
    do_push(8'h3C);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({valid, tx_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL hold_stable[%0d]: got v%b tx%h want v1 tx3c", i, valid, tx_data); end
    end
    c = cyc;
    st_next = 1;
    wait_res(r0 + 1, 50, ok);
    n_tests++;
    if (!ok || sent_log.size() <= s0) begin n_fail++; $display("FAIL hold_done: no transfer/result"); end
    else begin
      n_tests++;
      if (xcyc_log[s0] != c + 2 || sent_log[s0] !== 8'h3C) begin
        n_fail++; $display("FAIL hold_xfer: got cyc %0d data %h want cyc %0d data 3c", xcyc_log[s0], sent_log[s0], c + 2);
      end
    end
    exp_sent++; exp_recv++;
  endtask

  task automatic test_overflow();
    logic [7:0] w [5];
    int s0, r0;
    bit ok;
    for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
    st_mode = 1; st_dmin = 1; st_dmax = 1; st_next = 0;
    apply_reset();
    s0 = sent_log.size(); r0 = res_log.size();
    for (int i = 0; i < 4; i++) do_push(w[i]);
    n_tests++;
    if ({full, overflow} !== 2'b10) begin n_fail++; $display("FAIL ovf_full: got f%b o%b want f1 o0", full, overflow); end
    do_push(w[4]);
    n_tests++;
    if ({full, overflow} !== 2'b11) begin n_fail++; $display("FAIL ovf_drop: got f%b o%b want f1 o1", full, overflow); end
    st_next = 1;
    wait_res(r0 + 4, 200, ok);
    repeat (10) @(negedge clk);
    #1;
    n_tests++;
    if (!ok || sent_log.size() - s0 != 4 || empty !== 1'b1) begin
      n_fail++; $display("FAIL ovf_count: got %0d transfers empty %b want 4 empty 1", sent_log.size() - s0, empty);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (sent_log[s0+i] !== w[i]) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h want %h", i, sent_log[s0+i], w[i]); end
      end
    end

    // full FIFO with push and pop at the same edge
    st_next = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
    s0 = sent_log.size(); r0 = res_log.size();
    for (int i = 0; i < 4; i++) do_push(w[i]);
    @(negedge clk);
    #1 st_next = 1;
    do_push(w[4]);
    st_next = 0;
    n_tests++;
    if ({full, overflow, sent_log.size() - s0 == 1} !== 3'b101) begin
      n_fail++; $display("FAIL ovf_pushpop: got f%b o%b xfers %0d want f1 o0 xfers 1", full, overflow, sent_log.size() - s0);
    end
    st_next = 1;
    wait_res(r0 + 5, 200, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ovf_pushpop_done: got %0d results want 5", res_log.size() - r0); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (sent_log[s0+i] !== w[i]) begin n_fail++; $display("FAIL ovf_pushpop_order[%0d]: got %h want %h", i, sent_log[s0+i], w[i]); end
      end
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop_flag: got %b want 0", overflow); end
  endtask

  task automatic test_timeout();
    int s0, r0, x, t;
    bit ok;
    st_mode = 0; st_next = 1;
    apply_reset();
    s0 = sent_log.size(); r0 = res_log.size();
    do_push(8'h77);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (sent_log.size() > s0) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL timeout_xfer: no transfer"); end
    else begin
      x = xcyc_log[s0];
      t = -1;
      for (int i = 0; i < 40; i++) begin
        if (timeout_err === 1'b1) begin t = cyc; break; end
        @(negedge clk);
        #1;
      end
      n_tests++;
      if (t != x + 15) begin n_fail++; $display("FAIL timeout_latency: got cyc %0d want %0d", t, x + 15); end
    end
    n_tests++;
    if ({valid, sent_cnt, recv_cnt, timeout_err} !== {1'b0, 8'd1, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_state: got v%b s%0d r%0d t%b want v0 s1 r0 t1", valid, sent_cnt, recv_cnt, timeout_err);
    end
    st_force = 1'b1;
    repeat (3) @(negedge clk);
    #1 st_force = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (res_log.size() != r0 || recv_cnt !== 8'd0) begin
      n_fail++; $display("FAIL timeout_late_ready: got %0d captures recv %0d want 0", res_log.size() - r0, recv_cnt);
    end
    st_mode = 1; st_dmin = 2; st_dmax = 2;
    do_push(8'h99);
    wait_res(r0 + 1, 50, ok);
    n_tests++;
    if (!ok || res_log[r0] !== 8'h66) begin n_fail++; $display("FAIL timeout_recover: got ok %b result %h want 66", ok, ok ? res_log[r0] : 8'h00); end
  endtask

  task automatic test_async_reset();
    int s0, r0;
    st_mode = 1; st_dmin = 8; st_dmax = 8; st_next = 1;
    apply_reset();
    s0 = sent_log.size(); r0 = res_log.size();
    for (int i = 0; i < 3; i++) do_push(8'($urandom));
    @(negedge clk);
    #1;
    n_tests++;
    if (sent_log.size() - s0 != 1 || empty !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_pre: got xfers %0d empty %b valid %b want 1 0 0", sent_log.size() - s0, empty, valid);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({empty, full, valid, tx_data, sent_cnt, recv_cnt, result_valid, overflow, timeout_err}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL areset_immediate: got e%b f%b v%b tx%h s%h r%h rv%b o%b t%b", empty, full, valid,
                         tx_data, sent_cnt, recv_cnt, result_valid, overflow, timeout_err);
    end
    @(negedge clk);
    #1 reset = 1'b0;
    exp_sent = 0; exp_recv = 0;
    repeat (15) @(negedge clk);
    #1;
    n_tests++;
    if (res_log.size() != r0 || {recv_cnt, sent_cnt, empty} !== {8'd0, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL areset_after: got %0d captures r%0d s%0d e%b want 0 0 0 1", res_log.size() - r0, recv_cnt, sent_cnt, empty);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] w;
    int s0, r0, npush, cycles;
    bit ok;
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      st_mode = (p == 0) ? 2 : 1; st_dmin = 1; st_dmax = 6; st_next = 2;
      exp_q.delete();
      s0 = sent_log.size(); r0 = res_log.size();
      npush = 0; cycles = 0;
      while (npush < 150 && cycles < 5000) begin
        cycles++;
        if (npush - (sent_log.size() - s0) < 4 && $urandom_range(3, 0) != 0) begin
          w = 8'($urandom);
          do_push(w);
          exp_q.push_back(w);
          npush++;
        end else begin
          @(posedge clk);
          #1;
        end
      end
      wait_res(r0 + exp_q.size(), 3000, ok);
      n_tests++;
      if (!ok || npush != 150) begin n_fail++; $display("FAIL rand_done[%0d]: got %0d results want 150", p, res_log.size() - r0); end
      else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_tests++;
          if (sent_log[s0+i] !== exp_q[i] || res_log[r0+i] !== (exp_q[i] ^ 8'hFF)
              || rv_log[r0+i] - xcyc_log[s0+i] != del_log[s0+i]) begin
            n_fail++;
            $display("FAIL rand_xact[%0d.%0d]: got tx %h res %h lat %0d want tx %h res %h lat %0d", p, i,
                     sent_log[s0+i], res_log[r0+i], rv_log[r0+i] - xcyc_log[s0+i], exp_q[i], exp_q[i] ^ 8'hFF, del_log[s0+i]);
          end
        end
      end
      exp_sent += exp_q.size(); exp_recv += exp_q.size();
    end
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({sent_cnt, recv_cnt, overflow, timeout_err, empty} !== {8'(exp_sent), 8'(exp_recv), 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rand_counts_wrap: got s%0d r%0d o%b t%b e%b want s%0d r%0d o0 t0 e1", sent_cnt, recv_cnt,
                         overflow, timeout_err, empty, exp_sent % 256, exp_recv % 256);
    end
  endtask

  initial begin
    test_reset();
    test_delay1();
    test_zero_latency();
    test_hold();
    test_overflow();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
